// File: rtl/rfphoenix_thread_fetch_queue.sv
// rfphoenix_thread_fetch_queue
// Per-thread fetch-record FIFOs between the icache/fetch stage and decode.
// Each of NTHREADS threads owns a DEPTH-entry FIFO. One record per cycle is
// moved into a single output register, chosen round-robin among threads that
// have data and are neither stalled nor being flushed. A flush clears a
// thread's FIFO and cancels its record if it sits in the output register.
module rfphoenix_thread_fetch_queue #(
    parameter int NTHREADS = 6,
    parameter int DEPTH    = 4,
    parameter int DW       = 128,
    parameter int TIDW     = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enq_v,
    input  logic [TIDW-1:0]                       enq_tid,
    input  logic [DW-1:0]                         enq_dat,
    output logic [NTHREADS-1:0]                   full,
    input  logic [NTHREADS-1:0]                   flush,
    input  logic [NTHREADS-1:0]                   stall,
    output logic                                  deq_v,
    output logic [TIDW-1:0]                       deq_tid,
    output logic [DW-1:0]                         deq_dat,
    input  logic                                  deq_rdy,
    output logic [NTHREADS*($clog2(DEPTH)+1)-1:0] cnt,
    output logic                                  err_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0]   mem_q    [NTHREADS][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NTHREADS];
    logic [PW-1:0]   wr_ptr_d [NTHREADS];
    logic [PW-1:0]   rd_ptr_q [NTHREADS];
    logic [PW-1:0]   rd_ptr_d [NTHREADS];
    logic [CW-1:0]   count_q  [NTHREADS];
    logic [CW-1:0]   count_d  [NTHREADS];

    logic [TIDW-1:0] rr_q, rr_d;
    logic            deq_v_q, deq_v_d;
    logic [TIDW-1:0] deq_tid_q, deq_tid_d;
    logic [DW-1:0]   deq_dat_q, deq_dat_d;
    logic            err_q, err_d;

    logic [NTHREADS-1:0] enq_hit;
    logic [NTHREADS-1:0] enq_acc;
    logic [NTHREADS-1:0] elig;
    logic [NTHREADS-1:0] pop_hit;
    logic                tid_ok;
    logic                tgt_full;
    logic                tgt_flush;
    logic                stage_flushed;
    logic                load_ok;
    logic                found;
    int                  win_idx;
    int                  idx;
    logic [TIDW-1:0]     win_tid;
    logic [DW-1:0]       win_dat;

    // Occupancy and full flags come straight from the per-thread counts.
    always_comb begin
        full = '0;
        cnt  = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            full[t]            = (count_q[t] == CW'(DEPTH));
            cnt[t*CW +: CW]    = count_q[t];
        end
    end

    // Decode the enqueue target; a flushed target drops silently, a full or out-of-range one flags an error.
    always_comb begin
        tid_ok    = ({1'b0, enq_tid} < (TIDW+1)'(NTHREADS));
        tgt_full  = 1'b0;
        tgt_flush = 1'b0;
        enq_hit   = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            enq_hit[t] = (enq_tid == TIDW'(t));
            if (enq_hit[t]) begin
                tgt_full  = full[t];
                tgt_flush = flush[t];
            end
        end
        enq_acc = (enq_v && tid_ok && !tgt_full && !tgt_flush) ? enq_hit : '0;
        err_d   = enq_v && (!tid_ok || (tgt_full && !tgt_flush));
    end

    // Round-robin pick starting one past the last winner; a flush of the staged thread frees the output register.
    always_comb begin
        stage_flushed = 1'b0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (deq_tid_q == TIDW'(t)) begin
                stage_flushed = deq_v_q && flush[t];
            end
        end
        load_ok = !deq_v_q || deq_rdy || stage_flushed;

        elig = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            elig[t] = (count_q[t] != '0) && !stall[t] && !flush[t];
        end

        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int i = NTHREADS; i >= 1; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NTHREADS) begin
                idx = idx - NTHREADS;
            end
            for (int t = 0; t < NTHREADS; t++) begin
                if ((t == idx) && elig[t]) begin
                    found   = 1'b1;
                    win_idx = t;
                end
            end
        end

        pop_hit = '0;
        win_tid = '0;
        win_dat = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (found && load_ok && (win_idx == t)) begin
                pop_hit[t] = 1'b1;
                win_tid    = TIDW'(t);
                win_dat    = mem_q[t][rd_ptr_q[t]];
            end
        end
    end

    // Per-thread pointer and count update; flush wins over any enqueue or pop.
    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            if (flush[t]) begin
                wr_ptr_d[t] = '0;
                rd_ptr_d[t] = '0;
                count_d[t]  = '0;
            end else begin
                wr_ptr_d[t] = wr_ptr_q[t] + PW'(enq_acc[t]);
                rd_ptr_d[t] = rd_ptr_q[t] + PW'(pop_hit[t]);
                count_d[t]  = count_q[t] + CW'(enq_acc[t]) - CW'(pop_hit[t]);
            end
        end
    end

    // Output register loads the winner, or empties when loadable with nothing eligible.
    always_comb begin
        deq_v_d   = deq_v_q;
        deq_tid_d = deq_tid_q;
        deq_dat_d = deq_dat_q;
        rr_d      = rr_q;
        if (load_ok) begin
            deq_v_d = found;
            if (found) begin
                deq_tid_d = win_tid;
                deq_dat_d = win_dat;
                rr_d      = win_tid;
            end
        end
    end

    // Control state with asynchronous reset; round-robin starts so thread 0 is first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NTHREADS; t++) begin
                wr_ptr_q[t] <= '0;
                rd_ptr_q[t] <= '0;
                count_q[t]  <= '0;
            end
            rr_q      <= TIDW'(NTHREADS - 1);
            deq_v_q   <= 1'b0;
            deq_tid_q <= '0;
            deq_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                wr_ptr_q[t] <= wr_ptr_d[t];
                rd_ptr_q[t] <= rd_ptr_d[t];
                count_q[t]  <= count_d[t];
            end
            rr_q      <= rr_d;
            deq_v_q   <= deq_v_d;
            deq_tid_q <= deq_tid_d;
            deq_dat_q <= deq_dat_d;
            err_q     <= err_d;
        end
    end

    // Record storage needs no reset; validity is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NTHREADS; t++) begin
            if (enq_acc[t]) begin
                mem_q[t][wr_ptr_q[t]] <= enq_dat;
            end
        end
    end

    assign deq_v   = deq_v_q;
    assign deq_tid = deq_tid_q;
    assign deq_dat = deq_dat_q;
    assign err_ovf = err_q;

endmodule
